// File: rtl/seg7_mux_counter.sv
// Multi-digit BCD/hex up-counter with a time-multiplexed, registered 7-segment display driver.
// One instance per display; scans one digit per SCAN_DIV clocks with optional leading-zero blanking.
module seg7_mux_counter #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned TICK_DIV       = 32'h400000,
  parameter int unsigned SCAN_DIV       = 4096,
  parameter bit          DECIMAL        = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    blank_lz,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    wrap,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel
);

  localparam int unsigned VW = 4 * NUM_DIGITS;
  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

  logic [TW-1:0]         tick_cnt;
  logic [SW-1:0]         scan_cnt;
  logic [IW-1:0]         scan_idx;
  logic                  tick_c;
  logic                  carry_out_c;
  logic [VW-1:0]         inc_value_c;
  logic [3:0]            cur_nib_c;
  logic                  cur_blank_c;
  logic [6:0]            seg_c;
  logic [NUM_DIGITS-1:0] dig_c;

  // Active-high g..a pattern; decimal mode shows non-BCD nibbles as blank
  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    if (DECIMAL && (nib > 4'd9)) s = 7'h00;
    return s;
  endfunction

  assign tick_c = en && (tick_cnt == TW'(TICK_DIV - 1));

  // Ripple increment; in decimal mode any nibble >= 9 (including illegal loaded ones) rolls over
  always_comb begin : incr
    logic carry;
    carry       = 1'b1;
    inc_value_c = value;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (DECIMAL ? (value[4*i +: 4] >= 4'd9) : (value[4*i +: 4] == 4'hF)) begin
          inc_value_c[4*i +: 4] = 4'd0;
        end else begin
          inc_value_c[4*i +: 4] = value[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    carry_out_c = carry;
  end

  // Pick the scanned nibble and decide whether it is a blanked leading zero
  always_comb begin : pick
    logic zero_above;
    zero_above  = 1'b1;
    cur_nib_c   = 4'd0;
    cur_blank_c = 1'b0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_above = zero_above && (value[4*i +: 4] == 4'd0);
      if (scan_idx == IW'(i)) begin
        cur_nib_c   = value[4*i +: 4];
        cur_blank_c = blank_lz && (i > 0) && zero_above;
      end
    end
    seg_c = cur_blank_c ? 7'h00 : seg_encode(cur_nib_c);
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      dig_c[i] = (scan_idx == IW'(i));
    end
  end

  // Count path: clr > load > tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      value    <= '0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        tick_cnt <= '0;
        value    <= '0;
      end else if (load) begin
        tick_cnt <= '0;
        value    <= load_value;
      end else begin
        if (en) tick_cnt <= tick_c ? '0 : tick_cnt + TW'(1);
        if (tick_c) begin
          value <= inc_value_c;
          wrap  <= carry_out_c;
        end
      end
    end
  end

  // Digit scan runs regardless of en/clr/load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // Output register applies pin polarity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out <= SEG_OFF;
      dig_sel <= DIG_OFF;
    end else begin
      seg_out <= SEG_ACTIVE_LOW ? ~seg_c : seg_c;
      dig_sel <= DIG_ACTIVE_LOW ? ~dig_c : dig_c;
    end
  end

endmodule

// File: tb/tb_seg7_mux_counter.sv
// Bench for seg7_mux_counter: decimal and hex instances checked each cycle against an
// integer-arithmetic model of count, wrap and the scanned display.
module tb_seg7_mux_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en, clr, blank_lz, load_d, load_h;
  logic [15:0] lv_d, lv_h;
  logic [15:0] val_d, val_h;
  logic wrap_d, wrap_h;
  logic [6:0] seg_d, seg_h;
  logic [3:0] dig_d, dig_h;

  int errors = 0;
  int checks = 0;

  // model state: counts as plain integers
  int n_d, n_h, tc_d, tc_h, m, ld_n_d, ld_n_h;
  logic [6:0] e_seg_d, e_seg_h;
  logic [3:0] e_dig;
  logic e_wrap_d, e_wrap_h;
  int wraps_d, wraps_h;

  logic [6:0] enc_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  seg7_mux_counter #(.NUM_DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .DECIMAL(1'b1),
                     .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut_dec (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load_d), .load_value(lv_d),
    .blank_lz(blank_lz), .value(val_d), .wrap(wrap_d), .seg_out(seg_d), .dig_sel(dig_d));

  seg7_mux_counter #(.NUM_DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .DECIMAL(1'b0),
                     .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut_hex (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load_h), .load_value(lv_h),
    .blank_lz(blank_lz), .value(val_h), .wrap(wrap_h), .seg_out(seg_h), .dig_sel(dig_h));

  function automatic logic [15:0] to_vec(input int n, input int radix);
    int p;
    logic [15:0] v;
    p = 1;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      v[4*i +: 4] = 4'((n / p) % radix);
      p = p * radix;
    end
    return v;
  endfunction

  // Active-low segment pattern of digit idx of number n
  function automatic logic [6:0] disp(input int n, input int radix, input int idx, input logic blz);
    int p;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * radix;
    if (blz && idx > 0 && n < p) return 7'h7F;
    return ~enc_tab[(n / p) % radix];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n_d = 0; n_h = 0; tc_d = 0; tc_h = 0; m = 0;
  endtask

  task automatic model_edge();
    int sidx;
    logic tk;
    sidx    = (m / 2) % 4;
    e_dig   = 4'hF & ~(4'(1) << sidx);
    e_seg_d = disp(n_d, 10, sidx, blank_lz);
    e_seg_h = disp(n_h, 16, sidx, blank_lz);
    m++;
    e_wrap_d = 1'b0;
    tk = en && (tc_d == 3);
    if (clr) begin n_d = 0; tc_d = 0; end
    else if (load_d) begin n_d = ld_n_d; tc_d = 0; end
    else begin
      if (en) tc_d = (tc_d + 1) % 4;
      if (tk) begin n_d = (n_d + 1) % 10000; e_wrap_d = (n_d == 0); end
    end
    e_wrap_h = 1'b0;
    tk = en && (tc_h == 3);
    if (clr) begin n_h = 0; tc_h = 0; end
    else if (load_h) begin n_h = ld_n_h; tc_h = 0; end
    else begin
      if (en) tc_h = (tc_h + 1) % 4;
      if (tk) begin n_h = (n_h + 1) % 65536; e_wrap_h = (n_h == 0); end
    end
  endtask

  task automatic check_outputs();
    chk("value_dec", val_d, to_vec(n_d, 10));
    chk("wrap_dec", 16'(wrap_d), 16'(e_wrap_d));
    chk("seg_dec", 16'(seg_d), 16'(e_seg_d));
    chk("dig_dec", 16'(dig_d), 16'(e_dig));
    chk("value_hex", val_h, to_vec(n_h, 16));
    chk("wrap_hex", 16'(wrap_h), 16'(e_wrap_h));
    chk("seg_hex", 16'(seg_h), 16'(e_seg_h));
    chk("dig_hex", 16'(dig_h), 16'(e_dig));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic set_load(input int nd, input int nh);
    ld_n_d = nd; ld_n_h = nh;
    lv_d = to_vec(nd, 10); lv_h = to_vec(nh, 16);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_val_dec"}, val_d, 16'h0000);
    chk({tag, "_val_hex"}, val_h, 16'h0000);
    chk({tag, "_seg_dec"}, 16'(seg_d), 16'h007F);
    chk({tag, "_dig_dec"}, 16'(dig_d), 16'h000F);
    chk({tag, "_seg_hex"}, 16'(seg_h), 16'h007F);
    chk({tag, "_dig_hex"}, 16'(dig_h), 16'h000F);
    chk({tag, "_wrap_dec"}, 16'(wrap_d), 16'h0000);
    chk({tag, "_wrap_hex"}, 16'(wrap_h), 16'h0000);
  endtask

  initial begin
    en = 1'b0; clr = 1'b0; load_d = 1'b0; load_h = 1'b0; blank_lz = 1'b0;
    set_load(0, 0);
    model_reset();

    // held in reset
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");

    // free count from zero
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    step();
    chk("first_dig", 16'(dig_d), 16'h000E);
    chk("first_seg_zero", 16'(seg_d), 16'h0040);
    repeat (45) step();
    chk("count_0011", val_d, 16'h0011);

    // roll over from 9999 / FFFE
    set_load(9999, 65534);
    load_d = 1'b1; load_h = 1'b1;
    step();
    load_d = 1'b0; load_h = 1'b0;
    wraps_d = 0; wraps_h = 0;
    repeat (12) begin
      step();
      if (wrap_d === 1'b1) wraps_d++;
      if (wrap_h === 1'b1) wraps_h++;
    end
    chk("wrap_once_dec", 16'(wraps_d), 16'd1);
    chk("wrap_once_hex", 16'(wraps_h), 16'd1);

    // leading-zero blanking on 0042
    en = 1'b0; blank_lz = 1'b1;
    set_load(42, 66);
    load_d = 1'b1; load_h = 1'b1;
    step();
    load_d = 1'b0; load_h = 1'b0;
    repeat (8) begin
      step();
      case (dig_d)
        4'hE: chk("blank_d0", 16'(seg_d), 16'h0024);
        4'hD: chk("blank_d1", 16'(seg_d), 16'h0019);
        default: chk("blank_hi", 16'(seg_d), 16'h007F);
      endcase
    end
    blank_lz = 1'b0;

    // clr+load on the tick cycle of a would-be wrap
    set_load(9999, 65535);
    load_d = 1'b1; load_h = 1'b1;
    step();
    load_d = 1'b0; load_h = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 8 && tc_d != 3; k++) step();
    clr = 1'b1; load_d = 1'b1; load_h = 1'b1;
    step();
    clr = 1'b0; load_d = 1'b0; load_h = 1'b0;
    chk("clr_tick_val", val_d, 16'h0000);
    chk("clr_tick_wrap_dec", 16'(wrap_d), 16'h0000);
    chk("clr_tick_wrap_hex", 16'(wrap_h), 16'h0000);
    repeat (3) step();
    chk("clr_tick_hold", val_d, 16'h0000);
    step();
    chk("clr_tick_restart", val_d, 16'h0001);

    // randomized traffic
    repeat (1500) begin
      en  = ($urandom_range(9) != 0);
      clr = ($urandom_range(49) == 0);
      load_d = ($urandom_range(29) == 0);
      load_h = ($urandom_range(29) == 0);
      if ($urandom_range(99) == 0) blank_lz = ~blank_lz;
      set_load(($urandom_range(1) != 0) ? 9990 + int'($urandom_range(9)) : int'($urandom_range(9999)),
               ($urandom_range(1) != 0) ? 65520 + int'($urandom_range(15)) : int'($urandom_range(65535)));
      step();
    end
    clr = 1'b0; load_d = 1'b0; load_h = 1'b0;

    // asynchronous reset between clock edges
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_state("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1; blank_lz = 1'b0;
    repeat (20) step();
    chk("resume_after_rst", val_d, 16'h0005);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
